// File: rtl/rca_mp_sequencer.sv
// Word-serial multi-precision add/subtract controller around one 64-bit RCA.
// Define RCA_SEQ_OVF_EN to build the signed-overflow flag (ovf tied to 0 otherwise).

module rca64 (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    logic [64:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 64; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[64];
endmodule

module rca_mp_sequencer #(
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic        cin,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] a_word,
    input  logic [63:0] b_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] sum_word,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        cout,
    output logic        ovf
);
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          op_q, op_d;
    logic [63:0]   sum_q, sum_d;
    logic          vld_q, vld_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          cout_q, cout_d;

    logic [63:0]   b_eff;
    logic [63:0]   add_sum;
    logic          add_cout;
    logic          beat;
    logic          out_hs;
    logic          last_beat;

    assign b_eff = op_q ? ~b_word : b_word;

    rca64 u_add (
        .a    (a_word),
        .b    (b_eff),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign in_ready  = (state_q == RUN) && (!vld_q || out_ready);
    assign beat      = in_ready && in_valid;
    assign out_hs    = vld_q && out_ready;
    assign last_beat = beat && (cnt_q == LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        op_d    = op_q;
        sum_d   = sum_q;
        vld_d   = vld_q;
        last_d  = last_q;
        done_d  = 1'b0;
        cout_d  = cout_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    op_d    = op;
                    carry_d = cin ^ op;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (last_beat) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (out_hs) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new beat reloads the output register even while the old word drains.
        if (beat) begin
            sum_d   = add_sum;
            carry_d = add_cout;
            cnt_d   = cnt_q + CW'(1);
            vld_d   = 1'b1;
            last_d  = (cnt_q == LAST);
        end else if (out_hs) begin
            vld_d  = 1'b0;
            last_d = 1'b0;
        end

        if (last_beat) begin
            cout_d = add_cout ^ op_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= 1'b0;
            sum_q   <= '0;
            vld_q   <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            sum_q   <= sum_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
        end
    end

`ifdef RCA_SEQ_OVF_EN
    logic ovf_q, ovf_d;

    // Carry into the MSB xor carry out of it, using the inverted B for subtract.
    always_comb begin
        ovf_d = ovf_q;
        if (last_beat) begin
            ovf_d = a_word[63] ^ b_eff[63] ^ add_sum[63] ^ add_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign out_valid = vld_q;
    assign sum_word  = sum_q;
    assign out_last  = last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign cout      = cout_q;
endmodule

// File: tb/tb_rca_mp_sequencer.sv
// Randomised self-checking bench for rca_mp_sequencer (WORDS = 4).
// Expected results come from whole-operand integer arithmetic.

module tb_rca_mp_sequencer;
    localparam int W  = 4;
    localparam int NB = 64 * W;

`ifdef RCA_SEQ_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic        cin = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a_word = '0;
    logic [63:0] b_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] sum_word;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        cout;
    logic        ovf;

    int checks = 0;
    int failures = 0;

    logic [63:0] r_words [W];
    logic [W-1:0] r_lasts;
    int          r_nwords;
    int          r_ndone;
    int          r_done_cyc;
    logic        r_busy1;
    logic        r_rdy1;
    logic        r_busy_done;
    logic        r_cout;
    logic        r_ovf;
    logic [63:0] r_held [3];
    logic [2:0]  r_rdy_st;
    bit          r_tmo;

    always #5 clk = ~clk;

    rca_mp_sequencer #(.WORDS(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_word    (a_word),
        .b_word    (b_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_word  (sum_word),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Whole-width arithmetic: unsigned for carry/borrow, sign-extended for overflow.
    function automatic void model(
        input  logic [NB-1:0] a,
        input  logic [NB-1:0] b,
        input  logic          o,
        input  logic          c,
        output logic [NB-1:0] s,
        output logic          co,
        output logic          ov
    );
        logic [NB+1:0] sa, sb, u, r;
        sa = {{2{a[NB-1]}}, a};
        sb = {{2{b[NB-1]}}, b};
        if (!o) begin
            u  = {2'b00, a} + {2'b00, b} + (NB+2)'(c);
            co = u[NB];
            r  = sa + sb + (NB+2)'(c);
        end else begin
            u  = {2'b00, a} - {2'b00, b} - (NB+2)'(c);
            co = u[NB+1];
            r  = sa - sb - (NB+2)'(c);
        end
        s  = r[NB-1:0];
        ov = OVF_EN && (r[NB+1:NB-1] != 3'b000)
                    && (r[NB+1:NB-1] != 3'b111);
    endfunction

    function automatic logic [NB-1:0] rnd_wide();
        logic [NB-1:0] v;
        for (int i = 0; i < NB / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // mode 0: free flow, 1: 3-cycle stall after first output,
    // 2: random valid/ready, 3: free flow with a stray start in RUN.
    // Entered and left at posedge+1.
    task automatic run_op(
        input logic [NB-1:0] a,
        input logic [NB-1:0] b,
        input logic          o,
        input logic          c,
        input int            mode
    );
        int bi;
        int stall;
        int sidx;
        bi = 0;
        stall = 0;
        sidx = 0;
        r_nwords = 0;
        r_lasts = '0;
        r_ndone = 0;
        r_done_cyc = -1;
        r_busy1 = 1'b0;
        r_rdy1 = 1'b0;
        r_busy_done = 1'b1;
        r_rdy_st = '1;
        r_tmo = 1'b0;
        for (int i = 0; i < 3; i++) r_held[i] = '0;
        for (int cy = 0; cy < 300; cy++) begin
            if (cy == 0) begin
                start = 1'b1;
                op = o;
                cin = c;
            end else if (mode == 3 && cy == 2) begin
                start = 1'b1;
                op = ~o;
                cin = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            in_valid = (mode == 2) ? 1'($urandom) : 1'b1;
            a_word = (bi < W) ? a[bi*64 +: 64] : 64'h0;
            b_word = (bi < W) ? b[bi*64 +: 64] : 64'h0;
            if (mode == 1) out_ready = (stall == 0);
            else if (mode == 2) out_ready = 1'($urandom);
            else out_ready = 1'b1;
            @(negedge clk);
            if (cy == 1) begin
                r_busy1 = busy;
                r_rdy1 = in_ready;
            end
            if (mode == 1 && stall > 0) begin
                r_held[sidx] = sum_word;
                r_rdy_st[sidx] = in_ready;
                sidx++;
                stall--;
            end
            if (done) begin
                r_ndone++;
                if (r_done_cyc < 0) begin
                    r_done_cyc = cy;
                    r_busy_done = busy;
                end
            end
            if (out_valid && out_ready) begin
                if (r_nwords < W) begin
                    r_words[r_nwords] = sum_word;
                    r_lasts[r_nwords] = out_last;
                end
                r_nwords++;
                if (mode == 1 && r_nwords == 1) stall = 3;
            end
            if (in_valid && in_ready) bi++;
            if (r_done_cyc >= 0 && cy >= r_done_cyc + 2) break;
            @(posedge clk);
            #1;
        end
        if (r_done_cyc < 0) r_tmo = 1'b1;
        r_cout = cout;
        r_ovf = ovf;
        start = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(
        input string         tag,
        input logic [NB-1:0] a,
        input logic [NB-1:0] b,
        input logic          o,
        input logic          c
    );
        logic [NB-1:0] es;
        logic eco, eov;
        model(a, b, o, c, es, eco, eov);
        checks++;
        if (r_tmo !== 1'b0 || r_nwords != W) begin
            failures++;
            $display("FAIL %s timeout/count tmo=%0b words=%0d exp=%0d",
                     tag, r_tmo, r_nwords, W);
        end
        for (int i = 0; i < W; i++) begin
            checks++;
            if (r_words[i] !== es[i*64 +: 64]) begin
                failures++;
                $display("FAIL %s word%0d got=%h exp=%h",
                         tag, i, r_words[i], es[i*64 +: 64]);
            end
        end
        checks++;
        if (r_cout !== eco) begin
            failures++;
            $display("FAIL %s cout got=%b exp=%b", tag, r_cout, eco);
        end
        checks++;
        if (r_ovf !== eov) begin
            failures++;
            $display("FAIL %s ovf got=%b exp=%b", tag, r_ovf, eov);
        end
        checks++;
        if (r_lasts !== W'(1 << (W - 1))) begin
            failures++;
            $display("FAIL %s out_last got=%b exp=%b",
                     tag, r_lasts, W'(1 << (W - 1)));
        end
        checks++;
        if (r_ndone != 1 || r_busy_done !== 1'b0) begin
            failures++;
            $display("FAIL %s done pulses got=%0d busy@done=%b exp=1/0",
                     tag, r_ndone, r_busy_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_last, busy, done, cout, ovf} !== 7'b0
            || sum_word !== 64'h0) begin
            failures++;
            $display("FAIL reset outs got=%b sum=%h exp=0",
                     {in_ready, out_valid, out_last, busy, done, cout, ovf},
                     sum_word);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_carry_ripple();
        logic [NB-1:0] a, b;
        a = '1;
        b = NB'(1);
        run_op(a, b, 1'b0, 1'b0, 0);
        check_result("ripple", a, b, 1'b0, 1'b0);
        checks++;
        if (r_done_cyc != W + 2) begin
            failures++;
            $display("FAIL ripple done_cycle got=%0d exp=%0d",
                     r_done_cyc, W + 2);
        end
        checks++;
        if (r_busy1 !== 1'b1 || r_rdy1 !== 1'b1) begin
            failures++;
            $display("FAIL ripple start+1 busy=%b in_ready=%b exp=1/1",
                     r_busy1, r_rdy1);
        end
    endtask

    task automatic test_sub_underflow();
        logic [NB-1:0] a, b;
        a = '0;
        b = NB'(1);
        run_op(a, b, 1'b1, 1'b0, 0);
        check_result("sub_underflow", a, b, 1'b1, 1'b0);
    endtask

    task automatic test_signed_ovf();
        logic [NB-1:0] a, b;
        a = '1;
        a[NB-1] = 1'b0;
        b = NB'(1);
        run_op(a, b, 1'b0, 1'b0, 0);
        check_result("signed_ovf", a, b, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [NB-1:0] a, b, es;
        logic eco, eov;
        a = rnd_wide();
        b = rnd_wide();
        run_op(a, b, 1'b0, 1'b1, 1);
        check_result("backpressure", a, b, 1'b0, 1'b1);
        model(a, b, 1'b0, 1'b1, es, eco, eov);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (r_held[i] !== es[64 +: 64] || r_rdy_st[i] !== 1'b0) begin
                failures++;
                $display("FAIL stall%0d sum=%h in_ready=%b exp=%h/0",
                         i, r_held[i], r_rdy_st[i], es[64 +: 64]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [NB-1:0] a, b;
        int beats;
        bit hit;
        beats = 0;
        hit = 1'b0;
        start = 1'b1;
        op = 1'b0;
        cin = 1'b0;
        out_ready = 1'b1;
        for (int cy = 0; cy < 20 && !hit; cy++) begin
            in_valid = (cy > 0);
            a_word = 64'($urandom);
            b_word = 64'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) beats++;
            if (beats == 2) hit = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (!hit || {in_ready, out_valid, out_last, busy, done, cout, ovf} !== 7'b0
            || sum_word !== 64'h0) begin
            failures++;
            $display("FAIL reset_mid hit=%0b outs=%b sum=%h exp=0",
                     hit, {in_ready, out_valid, out_last, busy, done, cout, ovf},
                     sum_word);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b0;
        a = NB'(5);
        b = NB'(7);
        run_op(a, b, 1'b0, 1'b0, 0);
        checks++;
        if (r_words[0] !== 64'd12) begin
            failures++;
            $display("FAIL reset_mid word0 got=%h exp=%h", r_words[0], 64'd12);
        end
        check_result("after_reset", a, b, 1'b0, 1'b0);
    endtask

    task automatic test_start_ignored();
        logic [NB-1:0] a, b;
        a = rnd_wide();
        b = rnd_wide();
        run_op(a, b, 1'b0, 1'b0, 3);
        check_result("start_ignored", a, b, 1'b0, 1'b0);
        checks++;
        if (r_done_cyc != W + 2) begin
            failures++;
            $display("FAIL start_ignored done_cycle got=%0d exp=%0d",
                     r_done_cyc, W + 2);
        end
    endtask

    task automatic test_random();
        logic [NB-1:0] a, b;
        logic o, c;
        for (int n = 0; n < 24; n++) begin
            a = rnd_wide();
            b = rnd_wide();
            if (n % 4 == 1) b = a;
            if (n % 4 == 2) a[NB-1] = ~b[NB-1];
            o = 1'($urandom);
            c = 1'($urandom);
            run_op(a, b, o, c, (n % 2 == 0) ? 2 : 0);
            check_result("random", a, b, o, c);
        end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_sub_underflow();
        test_signed_ovf();
        test_backpressure();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rca_mp_sequencer.md
# rca_mp_sequencer

Word-serial multi-precision add/subtract controller built around one instance of the team's 64-bit ripple-carry adder (ports a, b, cin, sum, cout). It accepts WORDS operand word pairs, least-significant word first, over a valid/ready stream. Each pair goes through the shared adder with the carry registered between beats, and the sum words leave on a registered output stream. At the end of the operation it reports the final carry and the optional signed overflow.

## Interface
- WORDS, 4: operand length in 64-bit words; legal range 1..256.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins an operation when sampled in IDLE; ignored in any other state.
- op  in  1  operation select, sampled with start: 0 = add, 1 = subtract.
- cin  in  1  carry-in (add) or borrow-in (subtract), sampled with start.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid and in_ready are both high.
- a_word  in  64  operand A word.
- b_word  in  64  operand B word.
- out_valid  out  1  sum word valid.
- out_ready  in  1  downstream accepts the sum word.
- sum_word  out  64  result word.
- out_last  out  1  high with the final sum word.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the operation completes.
- cout  out  1  final carry-out (add) or borrow-out (subtract); held until the next start.
- ovf  out  1  signed overflow of the full-width result; held until the next start.

## Operation
- State machine:
  - IDLE → RUN on start.
  - RUN → FLUSH when beat WORDS-1 is accepted.
  - FLUSH → IDLE when the last sum word handshakes.
- Entry to RUN:
  - Latch op.
  - carry register = cin ^ op.
  - Beat counter = 0.
- Adder inputs:
  - a = a_word.
  - b = op ? ~b_word : b_word.
  - adder cin = carry register.
- On an accepted beat:
  - sum_word register ← adder sum.
  - carry register ← adder cout.
  - Counter increments.
  - out_valid is set.
  - out_last is set if the counter equals WORDS-1.
- Subtract computes A − B − cin. The reported cout equals ~(final adder carry), so 1 means borrow.
- Overflow is taken from the final word: MSB(a) ^ MSB(b after inversion) ^ MSB(sum) ^ final carry.
- in_ready = (state == RUN) && (!out_valid || out_ready). Beats are never accepted in IDLE or FLUSH.
- out_valid clears on an output handshake with no new beat accepted in the same cycle.
- cout and ovf update on the last accepted beat. They are stable from done until the next start.
- start while busy is ignored. op and cin are sampled only in IDLE.
- Reset:
  - Outputs return to 0.
  - State returns to IDLE.
  - Counter and carry are cleared.
  - Reset mid-operation discards in-flight words. No done is produced for the aborted operation.

## Timing
- Reset values: in_ready, out_valid, out_last, busy, done, cout, ovf = 0; sum_word = 0.
- start sampled at cycle t: busy = 1 and in_ready = 1 at t+1.
- Beat accepted at cycle k: sum_word and out_valid are visible at k+1. Latency is one cycle.
- With in_valid and out_ready held high, throughput is one word per cycle.
- Last output handshake at cycle m:
  - done = 1 at m+1, for one cycle.
  - busy = 0 at m+1.
  - The next start is accepted from m+1.
- Minimum start-to-done time is WORDS+2 cycles.
- While out_valid is high and out_ready is low:
  - sum_word and out_last stay stable.
  - in_ready stays low.
- Simultaneous output handshake and new beat: the register reloads with no bubble.

## Configuration
- RCA_SEQ_OVF_EN defined: ovf logic is built as described in Operation.
- RCA_SEQ_OVF_EN undefined: ovf is tied to 0, and no MSB tracking logic is synthesised.

## Test plan
- Add carry ripple (WORDS=4): A = all ones, B = 1, cin = 0 → sum words 0,0,0,0; cout = 1; ovf = 0; done at start+6 with no backpressure.
- Subtract underflow: A = 0, B = 1, op = 1, cin = 0 → every sum word 0xFFFF_FFFF_FFFF_FFFF; cout = 1 (borrow); ovf = 0.
- Signed overflow: A word3 = 0x7FFF_FFFF_FFFF_FFFF and words 0–2 all ones, B = 1, add → words 0–2 = 0 and word3 = 0x8000_0000_0000_0000; ovf = 1 with RCA_SEQ_OVF_EN, 0 without it; cout = 0.
- Backpressure: drop out_ready for 3 cycles after the first output → sum_word held, in_ready low for those 3 cycles, all four words delivered in order, out_last only on word 3.
- Reset mid-operation: assert rst after 2 accepted beats → next cycle all outputs 0 and busy = 0; a following add of 5 + 7 (one-word values, upper words 0) yields word0 = 12.
- start pulsed during RUN with op = 1 → ignored; the result matches the original add, and exactly one done pulse is produced.
